// File: rtl/msrv_32_imm_generator.sv
// RV32I immediate generator: selects/extends instruction bits into a 32-bit immediate, registered (1-cycle latency, no stall).
// Optional MSRV32_IMM_ILLEGAL_EN treats type code 111 as illegal (zero immediate, flag set).
module msrv_32_imm_generator (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:7] instr_in,
   input  logic [2:0]  imm_type_in,
   output logic [31:0] imm_out,
   output logic        imm_illegal_out
);

   localparam logic [2:0] IMM_I     = 3'b000;
   localparam logic [2:0] IMM_I_ALT = 3'b001;
   localparam logic [2:0] IMM_S     = 3'b010;
   localparam logic [2:0] IMM_B     = 3'b011;
   localparam logic [2:0] IMM_U     = 3'b100;
   localparam logic [2:0] IMM_J     = 3'b101;
   localparam logic [2:0] IMM_CSR   = 3'b110;
   localparam logic [2:0] IMM_RSVD  = 3'b111;

   logic        sign;
   logic [31:0] i_imm;
   logic [31:0] s_imm;
   logic [31:0] b_imm;
   logic [31:0] u_imm;
   logic [31:0] j_imm;
   logic [31:0] csr_imm;
   logic [31:0] imm_nxt;
   logic        illegal_nxt;

   assign sign    = instr_in[31];
   assign i_imm   = {{20{sign}}, instr_in[31:20]};
   assign s_imm   = {{20{sign}}, instr_in[31:25], instr_in[11:7]};
   assign b_imm   = {{20{sign}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
   assign u_imm   = {instr_in[31:12], 12'h000};
   assign j_imm   = {{12{sign}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
   // CSR uimm lives in the rs1 field and is never sign-extended.
   assign csr_imm = {27'b0, instr_in[19:15]};

   always_comb begin
      imm_nxt     = i_imm;
      illegal_nxt = 1'b0;
      case (imm_type_in)
         IMM_I, IMM_I_ALT: imm_nxt = i_imm;
         IMM_S:            imm_nxt = s_imm;
         IMM_B:            imm_nxt = b_imm;
         IMM_U:            imm_nxt = u_imm;
         IMM_J:            imm_nxt = j_imm;
         IMM_CSR:          imm_nxt = csr_imm;
         IMM_RSVD: begin
`ifdef MSRV32_IMM_ILLEGAL_EN
            imm_nxt     = 32'h0000_0000;
            illegal_nxt = 1'b1;
`else
            imm_nxt     = i_imm;
`endif
         end
         default:          imm_nxt = i_imm;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         imm_out         <= 32'h0000_0000;
         imm_illegal_out <= 1'b0;
      end else begin
         imm_out         <= imm_nxt;
         imm_illegal_out <= illegal_nxt;
      end
   end

endmodule

// File: tb/tb_msrv_32_imm_generator.sv
// Self-checking bench for msrv_32_imm_generator: directed vectors plus randomized stimulus against an arithmetic reference model.
module tb_msrv_32_imm_generator;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:7] instr_in;
   logic [2:0]  imm_type_in;
   logic [31:0] imm_out;
   logic        imm_illegal_out;

   int errors = 0;
   int checks = 0;

   msrv_32_imm_generator dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .instr_in        (instr_in),
      .imm_type_in     (imm_type_in),
      .imm_out         (imm_out),
      .imm_illegal_out (imm_illegal_out)
   );

   always #5 clk_in = ~clk_in;

`ifdef MSRV32_IMM_ILLEGAL_EN
   localparam bit ILLEGAL_EN = 1'b1;
`else
   localparam bit ILLEGAL_EN = 1'b0;
`endif

   // Reference model built from masks and shifts on the full 32-bit word.
   function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] t);
      logic signed [31:0] sins;
      logic [31:0] sx, hi20, hi12;
      sins = ins;
      sx   = sins >>> 20;
      hi20 = ins[31] ? 32'hFFFF_F000 : 32'h0;
      hi12 = ins[31] ? 32'hFFF0_0000 : 32'h0;
      case (t)
         3'd2:    return (sx & ~32'h1F) | ((ins >> 7) & 32'h1F);
         3'd3:    return hi20 | (((ins >> 7) & 32'h1) << 11) | (((ins >> 25) & 32'h3F) << 5)
                          | (((ins >> 8) & 32'hF) << 1);
         3'd4:    return ins & 32'hFFFF_F000;
         3'd5:    return hi12 | (ins & 32'h000F_F000) | (((ins >> 20) & 32'h1) << 11)
                          | (((ins >> 21) & 32'h3FF) << 1);
         3'd6:    return (ins >> 15) & 32'h1F;
         3'd7:    return ILLEGAL_EN ? 32'h0 : sx;
         default: return sx;
      endcase
   endfunction

   function automatic logic ref_ill(input logic [2:0] t);
      return ILLEGAL_EN && (t == 3'd7);
   endfunction

   task automatic drive(input logic [31:0] ins, input logic [2:0] t);
      instr_in    = ins[31:7];
      imm_type_in = t;
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      drive(32'hFFF0_0093, 3'd0);
      @(posedge clk_in); #1;
      checks++;
      if (imm_out !== 32'h0) begin
         errors++; $display("FAIL reset_imm: got %h expected %h", imm_out, 32'h0);
      end
      checks++;
      if (imm_illegal_out !== 1'b0) begin
         errors++; $display("FAIL reset_flag: got %b expected 0", imm_illegal_out);
      end
      rst_in = 1'b0;
      @(posedge clk_in); #1;
      checks++;
      if (imm_out !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL reset_release: got %h expected FFFFFFFF", imm_out);
      end
   endtask

   task automatic test_directed();
      logic [31:0] ins [9];
      logic [2:0]  typ [9];
      logic [31:0] exp [9];
      logic        expf[9];
      ins = '{32'hFFF00093, 32'hFFF00093, 32'h7FF00093, 32'h0020A423, 32'hFE000EE3,
              32'h123450B7, 32'h001000EF, 32'h300FD073, 32'hFFF00093};
      typ = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
      exp = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h000007FF, 32'h00000008, 32'hFFFFFFFC,
              32'h12345000, 32'h00000800, 32'h0000001F, (ILLEGAL_EN ? 32'h0 : 32'hFFFFFFFF)};
      expf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ILLEGAL_EN};
      for (int k = 0; k < 9; k++) begin
         drive(ins[k], typ[k]);
         @(posedge clk_in); #1;
         checks++;
         if (imm_out !== exp[k]) begin
            errors++;
            $display("FAIL directed_%0d imm (instr %h type %0d): got %h expected %h",
                     k, ins[k], typ[k], imm_out, exp[k]);
         end
         checks++;
         if (imm_illegal_out !== expf[k]) begin
            errors++;
            $display("FAIL directed_%0d flag: got %b expected %b", k, imm_illegal_out, expf[k]);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] ins;
      logic [2:0]  t;
      logic [31:0] e;
      for (int k = 0; k < 300; k++) begin
         ins = $urandom;
         t   = 3'($urandom_range(0, 7));
         drive(ins, t);
         @(posedge clk_in); #1;
         e = ref_imm(ins, t);
         checks++;
         if (imm_out !== e || imm_illegal_out !== ref_ill(t)) begin
            errors++;
            $display("FAIL random_%0d (instr %h type %0d): got %h/%b expected %h/%b",
                     k, ins, t, imm_out, imm_illegal_out, e, ref_ill(t));
         end
         if (t == 3'd3 || t == 3'd5) begin
            checks++;
            if (imm_out[0] !== 1'b0) begin
               errors++; $display("FAIL random_even_%0d: got bit0 %b expected 0", k, imm_out[0]);
            end
         end
         if (t == 3'd4) begin
            checks++;
            if (imm_out[11:0] !== 12'h000) begin
               errors++; $display("FAIL random_u_low_%0d: got %h expected 000", k, imm_out[11:0]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins, prev;
      for (int k = 0; k < 21; k++) begin
         ins  = $urandom;
         prev = imm_out;
         drive(ins, 3'(k % 7));
         #1;
         checks++;
         if (imm_out !== prev) begin
            errors++; $display("FAIL b2b_comb_%0d: got %h expected %h", k, imm_out, prev);
         end
         @(posedge clk_in); #1;
         checks++;
         if (imm_out !== ref_imm(ins, 3'(k % 7)) || imm_illegal_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_%0d (instr %h type %0d): got %h/%b expected %h/0",
                     k, ins, k % 7, imm_out, imm_illegal_out, ref_imm(ins, 3'(k % 7)));
         end
      end
   endtask

   task automatic test_mid_reset();
      drive(32'h123450B7, 3'd4);
      @(posedge clk_in); #1;
      rst_in = 1'b1;
      drive(32'h001000EF, 3'd7);
      @(posedge clk_in); #1;
      checks++;
      if (imm_out !== 32'h0 || imm_illegal_out !== 1'b0) begin
         errors++; $display("FAIL mid_reset: got %h/%b expected 00000000/0", imm_out, imm_illegal_out);
      end
      rst_in = 1'b0;
      drive(32'h001000EF, 3'd5);
      @(posedge clk_in); #1;
      checks++;
      if (imm_out !== 32'h0000_0800) begin
         errors++; $display("FAIL mid_reset_release: got %h expected 00000800", imm_out);
      end
   endtask

   initial begin
      rst_in = 1'b1;
      drive(32'h0, 3'd0);
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
